// File: rtl/pio_bank_avmm.sv
// pio_bank_avmm: Avalon-MM PIO bank with NUM_OUT_CH output registers and
// NUM_IN_CH input channels (2-FF sync, debounce, edge capture, masked IRQ).
// Optional feature macro: PIO_OUT_SETCLR_EN enables the OUT_SET / OUT_CLR
// write-only windows at 0x20-0x2F; without it those addresses are unmapped.
module pio_bank_avmm #(
  parameter int                DATA_W          = 32,
  parameter int                NUM_IN_CH       = 2,
  parameter int                NUM_OUT_CH      = 4,
  parameter int                DEBOUNCE_CYCLES = 50000,
  parameter int                EDGE_MODE       = 0,
  parameter logic [DATA_W-1:0] OUT_RESET       = '0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [5:0]                   avs_address,
  input  logic                         avs_read,
  input  logic                         avs_write,
  input  logic [DATA_W-1:0]            avs_writedata,
  input  logic [DATA_W/8-1:0]          avs_byteenable,
  output logic [DATA_W-1:0]            avs_readdata,
  output logic                         avs_readdatavalid,
  output logic                         irq,
  input  logic [NUM_IN_CH*DATA_W-1:0]  pio_in,
  output logic [NUM_OUT_CH*DATA_W-1:0] pio_out
);

  localparam int BE_W  = DATA_W / 8;
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  localparam logic [2:0] GRP_OUT  = 3'd0;
  localparam logic [2:0] GRP_IN   = 3'd1;
  localparam logic [2:0] GRP_CAP  = 3'd2;
  localparam logic [2:0] GRP_MASK = 3'd3;
  localparam logic [2:0] GRP_SET  = 3'd4;
  localparam logic [2:0] GRP_CLR  = 3'd5;

  typedef enum logic {ST_STABLE = 1'b0, ST_COUNT = 1'b1} db_state_t;

  // Expand byte enables into a bit mask.
  function automatic logic [DATA_W-1:0] be_to_mask(input logic [BE_W-1:0] be);
    logic [DATA_W-1:0] m;
    m = '0;
    for (int b = 0; b < BE_W; b++) begin
      m[b*8 +: 8] = {8{be[b]}};
    end
    return m;
  endfunction

  logic [DATA_W-1:0] out_r   [NUM_OUT_CH];
  logic [DATA_W-1:0] sync1_r [NUM_IN_CH];
  logic [DATA_W-1:0] sync2_r [NUM_IN_CH];
  logic [DATA_W-1:0] cand_r  [NUM_IN_CH];
  logic [DATA_W-1:0] deb_r   [NUM_IN_CH];
  logic [DATA_W-1:0] cap_r   [NUM_IN_CH];
  logic [DATA_W-1:0] mask_r  [NUM_IN_CH];
  logic [CNT_W-1:0]  cnt_r   [NUM_IN_CH];
  db_state_t         state_r [NUM_IN_CH];
  logic              primed_r[NUM_IN_CH];

  logic [DATA_W-1:0] cand_s  [NUM_IN_CH];
  logic [DATA_W-1:0] deb_s   [NUM_IN_CH];
  logic [DATA_W-1:0] edge_s  [NUM_IN_CH];
  logic [CNT_W-1:0]  cnt_s   [NUM_IN_CH];
  db_state_t         state_s [NUM_IN_CH];
  logic              primed_s[NUM_IN_CH];

  logic [DATA_W-1:0] readdata_r;
  logic              readdatavalid_r;
  logic              irq_r;
  logic [DATA_W-1:0] rd_s;
  logic              irq_s;

  logic [2:0]        grp_s;
  logic [2:0]        k_s;
  logic [DATA_W-1:0] bm_s;
  logic [DATA_W-1:0] wm_s;

  assign grp_s = avs_address[5:3];
  assign k_s   = avs_address[2:0];
  assign bm_s  = be_to_mask(avs_byteenable);
  assign wm_s  = avs_writedata & bm_s;

  assign avs_readdata      = readdata_r;
  assign avs_readdatavalid = readdatavalid_r;
  assign irq               = irq_r;

  genvar g;
  generate
    for (g = 0; g < NUM_OUT_CH; g++) begin : g_out
      assign pio_out[g*DATA_W +: DATA_W] = out_r[g];
    end
  endgenerate

  // Two-flop synchroniser on every raw input bit.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_IN_CH; i++) begin
      if (reset) begin
        sync1_r[i] <= '0;
        sync2_r[i] <= '0;
      end else begin
        sync1_r[i] <= pio_in[i*DATA_W +: DATA_W];
        sync2_r[i] <= sync1_r[i];
      end
    end
  end

  // Debouncer next state; an unprimed channel always runs one full debounce
  // so priming completes even when the input never changes after reset.
  always_comb begin
    for (int i = 0; i < NUM_IN_CH; i++) begin
      state_s[i]  = state_r[i];
      cand_s[i]   = cand_r[i];
      cnt_s[i]    = cnt_r[i];
      deb_s[i]    = deb_r[i];
      primed_s[i] = primed_r[i];
      edge_s[i]   = '0;
      case (state_r[i])
        ST_STABLE: begin
          if ((sync2_r[i] != cand_r[i]) || !primed_r[i]) begin
            state_s[i] = ST_COUNT;
            cand_s[i]  = sync2_r[i];
            cnt_s[i]   = '0;
          end else begin
            state_s[i] = ST_STABLE;
          end
        end
        ST_COUNT: begin
          if (sync2_r[i] != cand_r[i]) begin
            cand_s[i] = sync2_r[i];
            cnt_s[i]  = '0;
          end else if (cnt_r[i] == CNT_LAST) begin
            deb_s[i]    = cand_r[i];
            state_s[i]  = ST_STABLE;
            primed_s[i] = 1'b1;
            // Edges are only reported once the channel was already primed.
            if (primed_r[i]) begin
              case (EDGE_MODE)
                32'sd0:  edge_s[i] = cand_r[i] & ~deb_r[i];
                32'sd1:  edge_s[i] = ~cand_r[i] & deb_r[i];
                default: edge_s[i] = cand_r[i] ^ deb_r[i];
              endcase
            end else begin
              edge_s[i] = '0;
            end
          end else if (cnt_r[i] != CNT_MAX) begin
            cnt_s[i] = cnt_r[i] + CNT_W'(1);
          end else begin
            cnt_s[i] = cnt_r[i];
          end
        end
        default: begin
          state_s[i] = ST_STABLE;
        end
      endcase
    end
  end

  // Debouncer state registers.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_IN_CH; i++) begin
      if (reset) begin
        state_r[i]  <= ST_STABLE;
        cand_r[i]   <= '0;
        cnt_r[i]    <= '0;
        deb_r[i]    <= '0;
        primed_r[i] <= 1'b0;
      end else begin
        state_r[i]  <= state_s[i];
        cand_r[i]   <= cand_s[i];
        cnt_r[i]    <= cnt_s[i];
        deb_r[i]    <= deb_s[i];
        primed_r[i] <= primed_s[i];
      end
    end
  end

  // Edge capture (W1C, a new edge wins) and interrupt mask registers.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_IN_CH; i++) begin
      if (reset) begin
        cap_r[i]  <= '0;
        mask_r[i] <= '0;
      end else begin
        if (avs_write && (grp_s == GRP_CAP) && (k_s == 3'(i))) begin
          cap_r[i] <= (cap_r[i] & ~wm_s) | edge_s[i];
        end else begin
          cap_r[i] <= cap_r[i] | edge_s[i];
        end
        if (avs_write && (grp_s == GRP_MASK) && (k_s == 3'(i))) begin
          mask_r[i] <= (mask_r[i] & ~bm_s) | wm_s;
        end else begin
          mask_r[i] <= mask_r[i];
        end
      end
    end
  end

  // Output registers: direct byte-lane write, plus optional set/clear.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_OUT_CH; i++) begin
      if (reset) begin
        out_r[i] <= OUT_RESET;
      end else if (avs_write && (k_s == 3'(i))) begin
        case (grp_s)
          GRP_OUT: out_r[i] <= (out_r[i] & ~bm_s) | wm_s;
`ifdef PIO_OUT_SETCLR_EN
          GRP_SET: out_r[i] <= out_r[i] | wm_s;
          GRP_CLR: out_r[i] <= out_r[i] & ~wm_s;
`endif
          default: out_r[i] <= out_r[i];
        endcase
      end else begin
        out_r[i] <= out_r[i];
      end
    end
  end

  // Read mux and interrupt reduction; out-of-range channels contribute nothing.
  always_comb begin
    rd_s  = '0;
    irq_s = 1'b0;
    for (int i = 0; i < NUM_OUT_CH; i++) begin
      rd_s = rd_s | (out_r[i] & {DATA_W{(grp_s == GRP_OUT) && (k_s == 3'(i))}});
    end
    for (int i = 0; i < NUM_IN_CH; i++) begin
      rd_s  = rd_s | (deb_r[i]  & {DATA_W{(grp_s == GRP_IN)   && (k_s == 3'(i))}});
      rd_s  = rd_s | (cap_r[i]  & {DATA_W{(grp_s == GRP_CAP)  && (k_s == 3'(i))}});
      rd_s  = rd_s | (mask_r[i] & {DATA_W{(grp_s == GRP_MASK) && (k_s == 3'(i))}});
      irq_s = irq_s | (|(cap_r[i] & mask_r[i]));
    end
  end

  // Registered read response (fixed latency 1) and interrupt output.
  always_ff @(posedge clk) begin
    if (reset) begin
      readdata_r      <= '0;
      readdatavalid_r <= 1'b0;
      irq_r           <= 1'b0;
    end else begin
      readdatavalid_r <= avs_read;
      irq_r           <= irq_s;
      if (avs_read) begin
        readdata_r <= rd_s;
      end else begin
        readdata_r <= readdata_r;
      end
    end
  end

endmodule
